// File: rtl/operand_fetch_stage_if.sv
// Signal bundle between the operand fetch stage and the rest of the pipeline:
// IF/ID instruction fields, EX/MEM/WB forwarding sources, RegisterFile ports
// and the ID/EX pipeline register outputs.
interface operand_fetch_stage_if #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 5,
   parameter int PC_WIDTH        = 32,
   parameter int STALL_CNT_WIDTH = 16
);
   // IF/ID instruction
   logic                       id_valid;
   logic [ADDR_WIDTH-1:0]      id_rs1;
   logic [ADDR_WIDTH-1:0]      id_rs2;
   logic [ADDR_WIDTH-1:0]      id_rd;
   logic                       id_reg_write;
   logic                       id_mem_read;
   logic [DATA_WIDTH-1:0]      id_imm;
   logic [PC_WIDTH-1:0]        id_pc;
   logic                       flush;

   // forwarding sources
   logic [DATA_WIDTH-1:0]      ex_alu_result;
   logic [ADDR_WIDTH-1:0]      mem_rd;
   logic                       mem_reg_write;
   logic [DATA_WIDTH-1:0]      mem_data;
   logic [ADDR_WIDTH-1:0]      wb_rd;
   logic                       wb_reg_write;
   logic [DATA_WIDTH-1:0]      wb_data;

   // RegisterFile ports
   logic [ADDR_WIDTH-1:0]      read_address0;
   logic [ADDR_WIDTH-1:0]      read_address1;
   logic [DATA_WIDTH-1:0]      read_data0;
   logic [DATA_WIDTH-1:0]      read_data1;
   logic [(2**ADDR_WIDTH)-1:0] write_enable;
   logic [DATA_WIDTH-1:0]      write_data;

   // hazard and ID/EX register
   logic                       stall;
   logic                       ex_valid;
   logic [ADDR_WIDTH-1:0]      ex_rd;
   logic                       ex_reg_write;
   logic                       ex_mem_read;
   logic [DATA_WIDTH-1:0]      ex_rs1_data;
   logic [DATA_WIDTH-1:0]      ex_rs2_data;
   logic [DATA_WIDTH-1:0]      ex_imm;
   logic [PC_WIDTH-1:0]        ex_pc;
   logic [STALL_CNT_WIDTH-1:0] stall_count;

   // the operand fetch stage itself
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
             id_imm, id_pc, flush,
             ex_alu_result, mem_rd, mem_reg_write, mem_data,
             wb_rd, wb_reg_write, wb_data,
             read_data0, read_data1,
      output read_address0, read_address1, write_enable, write_data,
             stall, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
             ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, stall_count
   );

   // surrounding pipeline / RegisterFile
   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
             id_imm, id_pc, flush,
             ex_alu_result, mem_rd, mem_reg_write, mem_data,
             wb_rd, wb_reg_write, wb_data,
             read_data0, read_data1,
      input  read_address0, read_address1, write_enable, write_data,
             stall, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
             ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, stall_count
   );
endinterface

// File: rtl/operand_fetch_stage.sv
// ID-to-EX operand stage around a RegisterFile: drives the read addresses,
// forwards in-flight results (EX > MEM > WB > RF), stalls one cycle on a
// load-use hazard, builds the one-hot write-back enable and registers the
// instruction plus its operands into the ID/EX pipeline register.
module operand_fetch_stage #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 5,
   parameter int PC_WIDTH        = 32,
   parameter int STALL_CNT_WIDTH = 16
) (
   input logic                  clk,
   input logic                  reset,
   operand_fetch_stage_if.slave bus
);
   localparam int NUM_REGS = 2**ADDR_WIDTH;

   logic                       ex_valid_q;
   logic [ADDR_WIDTH-1:0]      ex_rd_q;
   logic                       ex_reg_write_q;
   logic                       ex_mem_read_q;
   logic [DATA_WIDTH-1:0]      ex_rs1_data_q;
   logic [DATA_WIDTH-1:0]      ex_rs2_data_q;
   logic [DATA_WIDTH-1:0]      ex_imm_q;
   logic [PC_WIDTH-1:0]        ex_pc_q;
   logic [STALL_CNT_WIDTH-1:0] stall_count_q;

   logic                       ex_fwd_ok;
   logic                       load_use;
   logic                       bubble;
   logic [DATA_WIDTH-1:0]      rs1_fwd;
   logic [DATA_WIDTH-1:0]      rs2_fwd;
   logic [NUM_REGS-1:0]        wr_en;

   assign bus.read_address0 = bus.id_rs1;
   assign bus.read_address1 = bus.id_rs2;
   assign bus.write_data    = bus.wb_data;

   // A load in EX has no data yet, so only non-load EX results may be forwarded.
   assign ex_fwd_ok = ex_valid_q && ex_reg_write_q && !ex_mem_read_q;

   // Load-use check is conservative: both sources are compared whether or not
   // the instruction actually reads them. A flush squashes the consumer, so it
   // suppresses the stall.
   assign load_use = bus.id_valid && !bus.flush && ex_valid_q && ex_mem_read_q &&
                     (ex_rd_q != '0) &&
                     ((ex_rd_q == bus.id_rs1) || (ex_rd_q == bus.id_rs2));

   assign bus.stall = load_use;
   assign bubble    = bus.flush || load_use;

   // rs1 operand: x0 reads as zero, then youngest producer wins
   always_comb begin
      if (bus.id_rs1 == '0)
         rs1_fwd = '0;
      else if (ex_fwd_ok && (ex_rd_q == bus.id_rs1))
         rs1_fwd = bus.ex_alu_result;
      else if (bus.mem_reg_write && (bus.mem_rd == bus.id_rs1))
         rs1_fwd = bus.mem_data;
      else if (bus.wb_reg_write && (bus.wb_rd == bus.id_rs1))
         rs1_fwd = bus.wb_data;
      else
         rs1_fwd = bus.read_data0;
   end

   // rs2 operand: same priority as rs1
   always_comb begin
      if (bus.id_rs2 == '0)
         rs2_fwd = '0;
      else if (ex_fwd_ok && (ex_rd_q == bus.id_rs2))
         rs2_fwd = bus.ex_alu_result;
      else if (bus.mem_reg_write && (bus.mem_rd == bus.id_rs2))
         rs2_fwd = bus.mem_data;
      else if (bus.wb_reg_write && (bus.wb_rd == bus.id_rs2))
         rs2_fwd = bus.wb_data;
      else
         rs2_fwd = bus.read_data1;
   end

   // One-hot RegisterFile write enable; x0 is never written.
   always_comb begin
      wr_en = '0;
      if (bus.wb_reg_write && (bus.wb_rd != '0))
         wr_en[bus.wb_rd] = 1'b1;
   end

   assign bus.write_enable = wr_en;

   // ID/EX pipeline register: bubble on flush or load-use, else capture ID.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid_q     <= 1'b0;
         ex_rd_q        <= '0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_rs1_data_q  <= '0;
         ex_rs2_data_q  <= '0;
         ex_imm_q       <= '0;
         ex_pc_q        <= '0;
      end else if (bubble) begin
         ex_valid_q     <= 1'b0;
         ex_rd_q        <= '0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_rs1_data_q  <= '0;
         ex_rs2_data_q  <= '0;
         ex_imm_q       <= '0;
         ex_pc_q        <= '0;
      end else begin
         ex_valid_q     <= bus.id_valid;
         ex_rd_q        <= bus.id_rd;
         ex_reg_write_q <= bus.id_valid && bus.id_reg_write;
         ex_mem_read_q  <= bus.id_valid && bus.id_mem_read;
         ex_rs1_data_q  <= rs1_fwd;
         ex_rs2_data_q  <= rs2_fwd;
         ex_imm_q       <= bus.id_imm;
         ex_pc_q        <= bus.id_pc;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_count_q <= '0;
      else if (load_use && (stall_count_q != '1))
         stall_count_q <= stall_count_q + 1'b1;
   end

   assign bus.ex_valid     = ex_valid_q;
   assign bus.ex_rd        = ex_rd_q;
   assign bus.ex_reg_write = ex_reg_write_q;
   assign bus.ex_mem_read  = ex_mem_read_q;
   assign bus.ex_rs1_data  = ex_rs1_data_q;
   assign bus.ex_rs2_data  = ex_rs2_data_q;
   assign bus.ex_imm       = ex_imm_q;
   assign bus.ex_pc        = ex_pc_q;
   assign bus.stall_count  = stall_count_q;
endmodule
